// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding req/ack fetch
// at a time, and presents the fetched word with its PC under valid/ready.
// Redirects are honoured in every state; stale in-flight responses are dropped.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] instr_code_q, instr_code_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] target_al;

    // Redirect targets are always word aligned.
    assign target_al = redirect_target & 32'hFFFF_FFFC;

    // Outputs decode purely from registered state.
    assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign instr_code  = instr_code_q;
    assign instr_pc    = instr_pc_q;

    // Next-state and datapath update; redirect outranks ready and ack data.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        instr_code_d = instr_code_q;
        instr_pc_d   = instr_pc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect) pc_d = target_al;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = target_al;
                    end else begin
                        instr_code_d = imem_rdata;
                        instr_pc_d   = pc_q;
                        pc_d         = pc_q + 32'd4;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Request is already out; keep it at the old address
                    // until the memory answers, then jump.
                    pending_pc_d = target_al;
                    state_d      = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = target_al;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    pc_d    = redirect ? target_al : pending_pc_q;
                    state_d = ST_FETCH;
                end else if (redirect) begin
                    pending_pc_d = target_al;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pending_pc_q <= '0;
            instr_code_q <= NOP_INSTR;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            instr_code_q <= instr_code_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder/control unit. It owns the program counter and fetches 32-bit instructions over a req/ack instruction-memory interface with variable latency. It presents one instruction at a time, together with its PC, under a valid/ready handshake. It accepts PC redirects (taken branch/jump, flush) at any time and discards any in-flight response those redirects make stale.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instr_code value while reset (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  fetch byte address; stable while imem_req=1
imem_rdata  input  32  instruction word; valid when imem_ack=1
imem_ack  input  1  response strobe; may be high in the same cycle as imem_req (zero-wait) or any later cycle
instr_valid  output  1  instr_code/instr_pc hold a fetched instruction
instr_ready  input  1  downstream consumes the instruction this cycle
instr_code  output  32  fetched instruction to decoder
instr_pc  output  32  address of instr_code
redirect  input  1  replace the fetch stream; honoured in any state
redirect_target  input  32  new PC; bits [1:0] forced to 0 internally

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Clock port is clk; reset port is reset.
- Reset, including mid-operation, applies: state=IDLE, pc=RESET_PC, pending_pc=0, instr_code=NOP_INSTR, instr_pc=0.
  - Resulting outputs: imem_req=0, instr_valid=0.
  - Any outstanding memory request is abandoned. The memory shares the same reset.
- Output decode:
  - imem_req=1 only in FETCH and DRAIN.
  - imem_addr=pc.
  - instr_valid=1 only in HOLD.
  - instr_code and instr_pc are registered.
- IDLE: next state FETCH. If redirect=1: pc<=target.
- FETCH:
  - ack=1, redirect=0: instr_code<=imem_rdata, instr_pc<=pc, pc<=pc+4, go to HOLD.
  - ack=1, redirect=1: discard rdata, pc<=target, stay in FETCH.
  - ack=0, redirect=1: pending_pc<=target, go to DRAIN.
  - ack=0, redirect=0: stay in FETCH with address held.
- HOLD:
  - redirect=1: drop the held instruction regardless of instr_ready, pc<=target, go to FETCH.
  - Else if instr_ready=1: go to FETCH.
  - Else stay; instr_code and instr_pc are stable.
- DRAIN: the in-flight request is kept high at its old address until ack.
  - ack=1: discard rdata, pc<=(redirect ? target : pending_pc), go to FETCH.
  - ack=0 with redirect=1: pending_pc<=target (latest redirect wins).
- Redirect has priority over instr_ready and over ack data in every state.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0. No misalignment trap.
- Latency with zero-wait memory: reset released at cycle 0 gives IDLE at 0, FETCH+ack at 1, instr_valid at 2. Steady-state throughput is one instruction per 2 cycles.
- The memory sees exactly one outstanding request at a time. A discarded response never reaches instr_code.

Test Plan:
- Reset release, zero-wait memory returning addr-derived data, instr_ready=1 -> imem_addr sequence 0,4,8,C. instr_valid pulses every other cycle with instr_pc 0,4,8. First valid is at cycle 2.
- Memory with 3-cycle ack latency -> imem_req stays high and imem_addr stable for 3 cycles. Exactly one HOLD per ack.
- HOLD with instr_ready=0 for 5 cycles -> instr_valid, instr_code and instr_pc stable. No imem_req. Fetch of pc+4 starts the cycle after ready.
- Redirect to 32'h100 while FETCH awaits a 4-cycle ack -> DRAIN: req stays high at the old address until ack. That data is never valid. Next request is to 0x100, and instr_pc 0x100 appears.
- Redirect target 32'h203 plus a second redirect to 0x300 during DRAIN -> the next fetch goes to 0x300. A single redirect to 0x203 fetches 0x200.
- Reset asserted mid-FETCH and in HOLD -> the next cycle shows imem_req=0, instr_valid=0, instr_code=32'h13. Fetch restarts at RESET_PC. PC at FFFF_FFFC increments to 0.
